// File: rtl/pred_perf_mon_pkg.sv
// Shared definitions for the prediction monitor: MMIO write addresses,
// readout select indices and the run/done state encoding.
package ridecore_mmio_pkg;

  localparam logic [31:0] MMIO_PUTC   = 32'h0000_0000;
  localparam logic [31:0] MMIO_INT    = 32'h0000_0004;
  localparam logic [31:0] MMIO_FINISH = 32'h0000_0008;
  localparam logic [31:0] MMIO_CLEAR  = 32'h0000_000C;

  localparam logic [2:0] SEL_CYCLES = 3'd0;
  localparam logic [2:0] SEL_PRNUM  = 3'd1;
  localparam logic [2:0] SEL_PRSU   = 3'd2;
  localparam logic [2:0] SEL_PRMI   = 3'd3;
  localparam logic [2:0] SEL_PRCOM  = 3'd4;
  localparam logic [2:0] SEL_LASTI  = 3'd5;
  localparam logic [2:0] SEL_DROP   = 3'd6;
  localparam logic [2:0] SEL_STATUS = 3'd7;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } run_state_e;

endpackage

// File: rtl/pred_perf_mon_if.sv
// Data-memory write port from the core plus the console byte stream
// toward the consumer; the monitor uses the slave side.
interface pred_perf_mon_if;

  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output dmem_we, dmem_addr, dmem_wdata, tx_ready,
    input  tx_valid, tx_data
  );

  modport slave (
    input  dmem_we, dmem_addr, dmem_wdata, tx_ready,
    output tx_valid, tx_data
  );

endinterface

// File: rtl/pred_perf_mon_fifo.sv
// Console byte FIFO without bypass; pointers carry one extra bit so a
// full queue and an empty queue are told apart.
module mmio_byte_fifo #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  output logic [7:0]                   head_data,
  output logic                         valid,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign count = wr_ptr - rd_ptr;
  assign valid = (wr_ptr != rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop on a full queue frees the slot the same-cycle push lands in.
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);

  assign head_data = valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pred_perf_mon.sv
// Branch-prediction performance counters, MMIO console sink and run/done
// control, with a select-driven readout port for FPGA inspection.
module pred_perf_mon
  import ridecore_mmio_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prmiss,
  input  logic              prsuccess,
  input  logic              combranch,
  pred_perf_mon_if.slave    bus,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  run_state_e       state_q;
  run_state_e       state_d;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] prnum_q;
  logic [CNT_W-1:0] prsu_q;
  logic [CNT_W-1:0] prmi_q;
  logic [CNT_W-1:0] prcom_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [31:0]      last_int_q;
  logic [CNT_W-1:0] status;
  logic             wr_putc;
  logic             wr_int;
  logic             wr_finish;
  logic             wr_clear;
  logic             fifo_valid;
  logic             fifo_full;
  logic [7:0]       fifo_head;
  logic [CW:0]      fifo_count;
  logic             drop;
  logic [1:0]       pred_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, val} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  assign wr_putc   = bus.dmem_we && (bus.dmem_addr == MMIO_PUTC);
  assign wr_int    = bus.dmem_we && (bus.dmem_addr == MMIO_INT);
  assign wr_finish = bus.dmem_we && (bus.dmem_addr == MMIO_FINISH);
  assign wr_clear  = bus.dmem_we && (bus.dmem_addr == MMIO_CLEAR);

  mmio_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_putc),
    .push_data (bus.dmem_wdata[7:0]),
    .pop       (bus.tx_ready),
    .head_data (fifo_head),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  assign bus.tx_valid = fifo_valid;
  assign bus.tx_data  = fifo_head;

  // Mirrors the FIFO's own acceptance rule: full with no draining pop loses the byte.
  assign drop = wr_putc && fifo_full && !(bus.tx_ready && fifo_valid);

  assign pred_inc = {1'b0, prmiss} + {1'b0, prsuccess};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (wr_clear) begin
      state_d = RUN;
    end else if (wr_finish) begin
      state_d = DONE;
    end
  end

  assign done = (state_q == DONE);

  // A clear wins over everything, so events in the clearing cycle vanish.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles_q   <= '0;
      prnum_q    <= '0;
      prsu_q     <= '0;
      prmi_q     <= '0;
      prcom_q    <= '0;
      last_int_q <= '0;
      drop_cnt_q <= '0;
    end else if (wr_clear) begin
      cycles_q   <= '0;
      prnum_q    <= '0;
      prsu_q     <= '0;
      prmi_q     <= '0;
      prcom_q    <= '0;
      last_int_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (state_q == RUN) begin
        cycles_q <= sat_add(cycles_q, 2'd1);
        prnum_q  <= sat_add(prnum_q, pred_inc);
        prsu_q   <= sat_add(prsu_q, {1'b0, prsuccess});
        prmi_q   <= sat_add(prmi_q, {1'b0, prmiss});
        prcom_q  <= sat_add(prcom_q, {1'b0, combranch});
        if (wr_int) begin
          last_int_q <= bus.dmem_wdata;
        end
      end
      if (drop) begin
        drop_cnt_q <= sat_add(drop_cnt_q, 2'd1);
      end
    end
  end

  always_comb begin
    status         = '0;
    status[CW:0]   = fifo_count;
    status[CW+1]   = done;
  end

  always_comb begin
    rd_data = '0;
    case (rd_sel)
      SEL_CYCLES: rd_data = cycles_q;
      SEL_PRNUM:  rd_data = prnum_q;
      SEL_PRSU:   rd_data = prsu_q;
      SEL_PRMI:   rd_data = prmi_q;
      SEL_PRCOM:  rd_data = prcom_q;
      SEL_LASTI:  rd_data = CNT_W'(last_int_q);
      SEL_DROP:   rd_data = drop_cnt_q;
      SEL_STATUS: rd_data = status;
      default:    rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_pred_perf_mon.sv
// Directed bench for pred_perf_mon: a 32-bit-counter instance for the
// main behaviour and an 8-bit-counter instance for saturation.
module tb_pred_perf_mon;
  import ridecore_mmio_pkg::*;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset, prmiss, prsuccess, combranch;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic        done;

  logic        reset8, prmiss8, prsuccess8, combranch8;
  logic [2:0]  rd_sel8;
  logic [7:0]  rd_data8;
  logic        done8;

  int vectors = 0;
  int miscompares = 0;

  pred_perf_mon_if bus ();
  pred_perf_mon_if bus8 ();

  pred_perf_mon #(.CNT_W(32), .FIFO_DEPTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .prmiss    (prmiss),
    .prsuccess (prsuccess),
    .combranch (combranch),
    .bus       (bus),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .done      (done)
  );

  pred_perf_mon #(.CNT_W(8), .FIFO_DEPTH(16)) dut8 (
    .clk       (clk),
    .reset     (reset8),
    .prmiss    (prmiss8),
    .prsuccess (prsuccess8),
    .combranch (combranch8),
    .bus       (bus8),
    .rd_sel    (rd_sel8),
    .rd_data   (rd_data8),
    .done      (done8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkReg(input string tag, input logic [2:0] sel,
                          input logic [31:0] expected);
    rd_sel = sel;
    #1;
    checkOutput(tag, rd_data, expected);
  endtask

  task automatic checkReg8(input string tag, input logic [2:0] sel,
                           input logic [31:0] expected);
    rd_sel8 = sel;
    #1;
    checkOutput(tag, {24'h0, rd_data8}, expected);
  endtask

  // One clock of strobes and an optional MMIO write, then everything idles.
  task automatic applyStimulus(input logic pm, input logic ps, input logic cb,
                               input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    prmiss         = pm;
    prsuccess      = ps;
    combranch      = cb;
    bus.dmem_we    = we;
    bus.dmem_addr  = addr;
    bus.dmem_wdata = wdata;
    tick();
    prmiss      = 1'b0;
    prsuccess   = 1'b0;
    combranch   = 1'b0;
    bus.dmem_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] ps_pat;
    logic [9:0] pm_pat;
    logic [9:0] cb_pat;
    ps_pat = 10'b0001001001;
    pm_pat = 10'b0010000010;
    cb_pat = 10'b1000110100;

    reset = 1'b0; prmiss = 1'b0; prsuccess = 1'b0; combranch = 1'b0;
    rd_sel = 3'd0;
    bus.dmem_we = 1'b0; bus.dmem_addr = '0; bus.dmem_wdata = '0; bus.tx_ready = 1'b0;
    reset8 = 1'b0; prmiss8 = 1'b0; prsuccess8 = 1'b0; combranch8 = 1'b0;
    rd_sel8 = 3'd0;
    bus8.dmem_we = 1'b0; bus8.dmem_addr = '0; bus8.dmem_wdata = '0; bus8.tx_ready = 1'b0;

    #1 reset = 1'b1; reset8 = 1'b1;
    #1;
    checkOutput("rst_tx_valid", {31'h0, bus.tx_valid}, 32'd0);
    checkOutput("rst_tx_data", {24'h0, bus.tx_data}, 32'd0);
    checkOutput("rst_done", {31'h0, done}, 32'd0);
    checkReg("rst_cycles", SEL_CYCLES, 32'd0);
    checkReg("rst_status", SEL_STATUS, 32'd0);
    tick();
    reset = 1'b0;

    // Ten cycles of mixed prediction outcomes
    for (int i = 0; i < 10; i++) begin
      applyStimulus(pm_pat[i], ps_pat[i], cb_pat[i], 1'b0, 32'h0, 32'h0);
    end
    checkReg("p1_cycles", SEL_CYCLES, 32'd10);
    checkReg("p1_prnum", SEL_PRNUM, 32'd5);
    checkReg("p1_prsu", SEL_PRSU, 32'd3);
    checkReg("p1_prmi", SEL_PRMI, 32'd2);
    checkReg("p1_prcom", SEL_PRCOM, 32'd4);

    // Clear discards its own cycle's events, then a double outcome adds two
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, MMIO_CLEAR, 32'h0);
    checkReg("clr_prnum", SEL_PRNUM, 32'd0);
    checkReg("clr_cycles", SEL_CYCLES, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    checkReg("both_prnum", SEL_PRNUM, 32'd2);
    checkReg("both_prsu", SEL_PRSU, 32'd1);
    checkReg("both_prmi", SEL_PRMI, 32'd1);
    checkReg("both_cycles", SEL_CYCLES, 32'd1);

    // last_int, finish, frozen counters in DONE, then clear back to RUN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_INT, 32'hDEAD_BEEF);
    checkReg("last_int", SEL_LASTI, 32'hDEAD_BEEF);
    checkOutput("pre_fin_done", {31'h0, done}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_FINISH, 32'h0);
    checkOutput("fin_done", {31'h0, done}, 32'd1);
    checkReg("fin_cycles", SEL_CYCLES, 32'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_INT, 32'h1234_5678);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_FINISH, 32'h0);
    checkReg("frz_prsu", SEL_PRSU, 32'd1);
    checkReg("frz_cycles", SEL_CYCLES, 32'd3);
    checkReg("frz_last_int", SEL_LASTI, 32'hDEAD_BEEF);
    checkOutput("frz_done", {31'h0, done}, 32'd1);
    checkReg("frz_status", SEL_STATUS, 32'h20);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_CLEAR, 32'h0);
    checkOutput("clr_done", {31'h0, done}, 32'd0);
    checkReg("clr2_prsu", SEL_PRSU, 32'd0);
    checkReg("clr2_last_int", SEL_LASTI, 32'd0);
    checkReg("clr2_cycles", SEL_CYCLES, 32'd0);

    // Overfill the FIFO with no consumer
    bus.tx_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_PUTC, 32'h41);
    checkOutput("first_tx_valid", {31'h0, bus.tx_valid}, 32'd1);
    checkReg("first_count", SEL_STATUS, 32'd1);
    for (int i = 1; i < 18; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_PUTC, 32'h41 + 32'(i));
    end
    checkReg("ovf_drop", SEL_DROP, 32'd2);
    checkReg("ovf_status", SEL_STATUS, 32'h10);
    checkOutput("ovf_head", {24'h0, bus.tx_data}, 32'h41);

    bus.tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_valid", {31'h0, bus.tx_valid}, 32'd1);
      checkOutput("drain_data", {24'h0, bus.tx_data}, 32'h41 + 32'(i));
      tick();
    end
    checkOutput("drained_valid", {31'h0, bus.tx_valid}, 32'd0);
    checkReg("drained_status", SEL_STATUS, 32'd0);

    // Refill to full, then push and pop together
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_PUTC, 32'h61 + 32'(i));
    end
    checkReg("refill_status", SEL_STATUS, 32'h10);
    bus.tx_ready = 1'b1;
    checkOutput("pp_head_before", {24'h0, bus.tx_data}, 32'h61);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_PUTC, 32'h71);
    bus.tx_ready = 1'b0;
    checkReg("pp_drop", SEL_DROP, 32'd2);
    checkReg("pp_status", SEL_STATUS, 32'h10);
    checkOutput("pp_head_after", {24'h0, bus.tx_data}, 32'h62);

    // In DONE a drop still counts; then reset lands between edges
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_FINISH, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MMIO_PUTC, 32'h7A);
    checkReg("done_drop", SEL_DROP, 32'd3);
    checkReg("done_status", SEL_STATUS, 32'h30);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    #5 reset = 1'b1;
    #1;
    checkOutput("arst_tx_valid", {31'h0, bus.tx_valid}, 32'd0);
    checkOutput("arst_tx_data", {24'h0, bus.tx_data}, 32'd0);
    checkOutput("arst_done", {31'h0, done}, 32'd0);
    checkReg("arst_cycles", SEL_CYCLES, 32'd0);
    checkReg("arst_drop", SEL_DROP, 32'd0);
    checkReg("arst_status", SEL_STATUS, 32'd0);
    tick();
    reset = 1'b0;

    // Saturation on the 8-bit-counter instance
    reset8 = 1'b0;
    prsuccess8 = 1'b1;
    for (int i = 0; i < 254; i++) begin
      tick();
    end
    checkReg8("s8_prsu_254", SEL_PRSU, 32'd254);
    checkReg8("s8_prnum_254", SEL_PRNUM, 32'd254);
    prmiss8 = 1'b1;
    tick();
    prmiss8 = 1'b0;
    checkReg8("s8_prnum_sat", SEL_PRNUM, 32'd255);
    checkReg8("s8_prsu_255", SEL_PRSU, 32'd255);
    checkReg8("s8_prmi", SEL_PRMI, 32'd1);
    tick();
    prsuccess8 = 1'b0;
    checkReg8("s8_prsu_sat", SEL_PRSU, 32'd255);
    checkReg8("s8_cycles_sat", SEL_CYCLES, 32'd255);
    tick();
    checkReg8("s8_cycles_hold", SEL_CYCLES, 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pred_perf_mon.md
# pred_perf_mon

Synthesizable branch-prediction performance monitor and memory-mapped simulation I/O sink. It sits directly downstream of the pipeline's commit-side prediction outcome strobes (`prmiss`, `prsuccess`, `combranch`) and of the core's data-memory write port. It replaces the bench-only counting and console printing with hardware counters, a console byte FIFO and a run/done state machine. Results are readable on FPGA through a select/readout port.

## Interface
Parameters:
- `CNT_W`, 32: width of every counter; saturating.
- `FIFO_DEPTH`, 16: console byte FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `prmiss`  in  1  branch misprediction resolved this cycle.
- `prsuccess`  in  1  branch prediction confirmed this cycle.
- `combranch`  in  1  branch committed this cycle.
- `dmem_we`  in  1  data-memory write strobe.
- `dmem_addr`  in  32  write address.
- `dmem_wdata`  in  32  write data.
- `tx_valid`  out  1  console byte available.
- `tx_data`  out  8  console byte.
- `tx_ready`  in  1  consumer accepts byte when `tx_valid && tx_ready`.
- `rd_sel`  in  3  readout select.
- `rd_data`  out  CNT_W  selected register, combinational from `rd_sel`.
- `done`  out  1  program signalled finish.

## Operation
- MMIO decode, only when `dmem_we`: 0x0 pushes `dmem_wdata[7:0]` into the FIFO; 0x4 latches `dmem_wdata` into `last_int`; 0x8 ends the run (RUN→DONE); 0xC clears all counters, `last_int`, `drop_cnt`, and forces RUN. Other addresses are ignored.
- States: RUN (reset state) and DONE.
  - RUN: counters update every cycle.
  - DONE: counters and `last_int` freeze; the FIFO keeps draining and accepting pushes; `done`=1.
  - DONE→RUN only on an 0xC write or `reset`.
  - In DONE, a further 0x8 write has no effect.
- Counters, all saturating at 2^CNT_W−1:
  - `cycles`: +1 per RUN cycle.
  - `prsu`: +prsuccess.
  - `prmi`: +prmiss.
  - `prnum`: +(prmiss+prsuccess). Both asserted adds 2; if that would pass the maximum, it saturates.
  - `prcom`: +combranch.
- The cycle containing the 0x8 write still counts. The cycle containing the 0xC write clears, and its own events are discarded.
- FIFO push when full and no pop in the same cycle: the byte is dropped and `drop_cnt` increments (saturating). `drop_cnt` counts in both states.
- `rd_sel` map: 0 cycles, 1 prnum, 2 prsu, 3 prmi, 4 prcom, 5 last_int, 6 drop_cnt, 7 status = {zero-pad, done, fifo_count[log2(FIFO_DEPTH):0]}.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `done`=0, all counters and `last_int`=0, state RUN, FIFO empty.
- Counter, `last_int`, `done` and state changes are visible on `rd_data` and `done` the cycle after the triggering edge.
- FIFO has no bypass: a push into an empty FIFO raises `tx_valid` the next cycle. `tx_data` is the head entry and is stable while `tx_valid && !tx_ready`.
- Push and pop in the same cycle when full: the pop frees a slot, the push is accepted, and no drop occurs. Push and pop in the same cycle when empty: no pop happens, the push is accepted, and the count becomes 1.
- Pointer wrap is modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- Asynchronous reset mid-operation clears FIFO contents and counters immediately. Outputs take their reset values without waiting for a clock edge.

## Structure
- Shared package `ridecore_mmio_pkg`: MMIO address constants (0x0, 0x4, 0x8, 0xC), `rd_sel` index constants, and the RUN/DONE state enum.
- Sub-module `mmio_byte_fifo`, parameterized by `FIFO_DEPTH`. Ports: push, push data, pop, head data, valid, full, count.
- Top level holds the decode, counters, state machine and readout mux.

## Test plan
- Reset, then 10 cycles with `prsuccess` pulsed 3×, `prmiss` 2×, `combranch` 4× → rd_sel 1/2/3/4 read 5/3/2/4; cycles reads 10.
- `prmiss` and `prsuccess` asserted together for 1 cycle → prnum=2, prsu=1, prmi=1.
- Write 0x8 at cycle 20, then pulse `prsuccess` → `done`=1 from cycle 21, prsu unchanged. Then write 0xC → all counters 0, `done`=0.
- `tx_ready`=0, push 18 bytes 0x41..0x52 with FIFO_DEPTH=16 → drop_cnt=2, status count=16. Raise `tx_ready` → exactly 0x41..0x50 drained in order, then `tx_valid`=0.
- Full FIFO with simultaneous push and pop → drop_cnt unchanged, count stays 16.
- Force the counter to 2^CNT_W−1 (CNT_W=8 build), then one `prsuccess` → prsu stays 255. Assert `reset` mid-stream → all outputs zero before the next edge.
